// File: rtl/clock_tx_formatter.sv
// clock_tx_formatter: serialises a snapshot of the clock and alarm BCD digits
// into the 15-byte ASCII frame "Mm:Ss Aa:Bb X\r\n" over a rdy/ack byte handshake.
// rst drives the flop clears directly, so the first clk edge after release
// already accepts a frame request.
module clock_tx_formatter (
    input  logic       clk,
    input  logic       rst,
    input  logic       oneSecStrb,
    input  logic       fmt_en,
    input  logic [3:0] di_Mtens,
    input  logic [3:0] di_Mones,
    input  logic [3:0] di_Stens,
    input  logic [3:0] di_Sones,
    input  logic [3:0] di_AMtens,
    input  logic [3:0] di_AMones,
    input  logic [3:0] di_AStens,
    input  logic [3:0] di_ASones,
    input  logic       dicAlarmArmed,
    input  logic       dicAlarmTrig,
    input  logic       tx_ack,
    output logic       L3_tx_data_rdy,
    output logic [7:0] L3_tx_data,
    output logic       fmt_busy,
    output logic       fmt_overrun
);

    localparam int unsigned DIG_W  = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 4;

    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(14);
    localparam logic [BYTE_W-1:0] ASCII_ZERO  = 8'h30;
    localparam logic [BYTE_W-1:0] ASCII_QMARK = 8'h3F;
    localparam logic [BYTE_W-1:0] ASCII_COLON = 8'h3A;
    localparam logic [BYTE_W-1:0] ASCII_SPACE = 8'h20;
    localparam logic [BYTE_W-1:0] ASCII_BANG  = 8'h21;
    localparam logic [BYTE_W-1:0] ASCII_A     = 8'h41;
    localparam logic [BYTE_W-1:0] ASCII_DASH  = 8'h2D;
    localparam logic [BYTE_W-1:0] ASCII_CR    = 8'h0D;
    localparam logic [BYTE_W-1:0] ASCII_LF    = 8'h0A;

    // Frozen copy of every input that contributes to a frame
    typedef struct packed {
        logic [DIG_W-1:0] mt;
        logic [DIG_W-1:0] mo;
        logic [DIG_W-1:0] st;
        logic [DIG_W-1:0] so;
        logic [DIG_W-1:0] amt;
        logic [DIG_W-1:0] amo;
        logic [DIG_W-1:0] ast;
        logic [DIG_W-1:0] aso;
        logic             armed;
        logic             trig;
    } snap_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                pending_q, pending_d;
    snap_t               snap_q, snap_d;
    logic                overrun_q, overrun_d;
    logic                rdy_q, rdy_d;
    logic [BYTE_W-1:0]   data_q, data_d;
    logic                busy_q, busy_d;

    snap_t               live_snap;
    logic                strb_ok;

    // BCD digit to ASCII; non-decimal codes are flagged with '?'
    function automatic logic [BYTE_W-1:0] enc_digit(input logic [DIG_W-1:0] d);
        if (d <= DIG_W'(9)) begin
            return ASCII_ZERO + BYTE_W'(d);
        end
        return ASCII_QMARK;
    endfunction

    // Status character: a triggered alarm outranks a merely armed one
    function automatic logic [BYTE_W-1:0] enc_status(input logic armed, input logic trig);
        if (trig) begin
            return ASCII_BANG;
        end
        if (armed) begin
            return ASCII_A;
        end
        return ASCII_DASH;
    endfunction

    // Byte at position idx of the frame built from snapshot s
    function automatic logic [BYTE_W-1:0] frame_byte(input snap_t s, input logic [IDX_W-1:0] idx);
        logic [BYTE_W-1:0] b;
        case (idx)
            IDX_W'(0):  b = enc_digit(s.mt);
            IDX_W'(1):  b = enc_digit(s.mo);
            IDX_W'(2):  b = ASCII_COLON;
            IDX_W'(3):  b = enc_digit(s.st);
            IDX_W'(4):  b = enc_digit(s.so);
            IDX_W'(5):  b = ASCII_SPACE;
            IDX_W'(6):  b = enc_digit(s.amt);
            IDX_W'(7):  b = enc_digit(s.amo);
            IDX_W'(8):  b = ASCII_COLON;
            IDX_W'(9):  b = enc_digit(s.ast);
            IDX_W'(10): b = enc_digit(s.aso);
            IDX_W'(11): b = ASCII_SPACE;
            IDX_W'(12): b = enc_status(s.armed, s.trig);
            IDX_W'(13): b = ASCII_CR;
            IDX_W'(14): b = ASCII_LF;
            default:    b = 8'h00;
        endcase
        return b;
    endfunction

    // Gather live inputs into snapshot form and qualify the frame request
    always_comb begin
        live_snap.mt    = di_Mtens;
        live_snap.mo    = di_Mones;
        live_snap.st    = di_Stens;
        live_snap.so    = di_Sones;
        live_snap.amt   = di_AMtens;
        live_snap.amo   = di_AMones;
        live_snap.ast   = di_AStens;
        live_snap.aso   = di_ASones;
        live_snap.armed = dicAlarmArmed;
        live_snap.trig  = dicAlarmTrig;
        strb_ok         = oneSecStrb & fmt_en;
    end

    // Next-state: frame sequencing, request queueing and next output byte
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        snap_d    = snap_q;
        overrun_d = overrun_q;

        case (state_q)
            IDLE: begin
                if (strb_ok) begin
                    state_d = SEND;
                    idx_d   = '0;
                    snap_d  = live_snap;
                end
            end
            SEND: begin
                if (tx_ack && (idx_q == LAST_IDX)) begin
                    if (!pending_q && !strb_ok) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        // Chain straight into the next frame; a request arriving
                        // while a queued one is consumed becomes the new queued one
                        snap_d    = live_snap;
                        idx_d     = '0;
                        pending_d = pending_q & strb_ok;
                    end
                end else begin
                    if (tx_ack) begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                    if (strb_ok) begin
                        if (pending_q) begin
                            overrun_d = 1'b1;
                        end else begin
                            pending_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase

        rdy_d  = (state_d == SEND);
        busy_d = (state_d == SEND);
        data_d = rdy_d ? frame_byte(snap_d, idx_d) : 8'h00;
    end

    // State and registered-output update with asynchronous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pending_q <= 1'b0;
            snap_q    <= '0;
            overrun_q <= 1'b0;
            rdy_q     <= 1'b0;
            data_q    <= 8'h00;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            snap_q    <= snap_d;
            overrun_q <= overrun_d;
            rdy_q     <= rdy_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
        end
    end

    assign L3_tx_data_rdy = rdy_q;
    assign L3_tx_data     = data_q;
    assign fmt_busy       = busy_q;
    assign fmt_overrun    = overrun_q;

endmodule

// File: tb/tb_clock_tx_formatter.sv
// Testbench for clock_tx_formatter: directed scenarios plus randomized traffic
// checked against a queue-based byte-stream model.
module tb_clock_tx_formatter;

    logic       clk = 1'b0;
    logic       rst;
    logic       oneSecStrb;
    logic       fmt_en;
    logic [3:0] di_Mtens, di_Mones, di_Stens, di_Sones;
    logic [3:0] di_AMtens, di_AMones, di_AStens, di_ASones;
    logic       dicAlarmArmed, dicAlarmTrig;
    logic       tx_ack;
    logic       L3_tx_data_rdy;
    logic [7:0] L3_tx_data;
    logic       fmt_busy;
    logic       fmt_overrun;

    int n_tests = 0;
    int n_fail  = 0;

    typedef logic [7:0] frame_t [15];

    // Model: the byte stream still owed to the transmitter, plus queued/dropped requests
    logic [7:0] mq[$];
    bit         m_pending;
    bit         m_overrun;

    clock_tx_formatter dut (
        .clk            (clk),
        .rst            (rst),
        .oneSecStrb     (oneSecStrb),
        .fmt_en         (fmt_en),
        .di_Mtens       (di_Mtens),
        .di_Mones       (di_Mones),
        .di_Stens       (di_Stens),
        .di_Sones       (di_Sones),
        .di_AMtens      (di_AMtens),
        .di_AMones      (di_AMones),
        .di_AStens      (di_AStens),
        .di_ASones      (di_ASones),
        .dicAlarmArmed  (dicAlarmArmed),
        .dicAlarmTrig   (dicAlarmTrig),
        .tx_ack         (tx_ack),
        .L3_tx_data_rdy (L3_tx_data_rdy),
        .L3_tx_data     (L3_tx_data),
        .fmt_busy       (fmt_busy),
        .fmt_overrun    (fmt_overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] enc(input logic [3:0] d);
        return (d < 4'd10) ? (8'd48 + {4'd0, d}) : 8'd63;
    endfunction

    function automatic frame_t make_frame(input logic [3:0] mt, mo, st, so, amt, amo, ast, aso,
                                          input logic armed, trig);
        logic [7:0] stat;
        frame_t f;
        stat = trig ? 8'h21 : (armed ? 8'h41 : 8'h2D);
        f = '{enc(mt), enc(mo), 8'h3A, enc(st), enc(so), 8'h20,
              enc(amt), enc(amo), 8'h3A, enc(ast), enc(aso), 8'h20,
              stat, 8'h0D, 8'h0A};
        return f;
    endfunction

    task automatic push_live_frame();
        frame_t f;
        f = make_frame(di_Mtens, di_Mones, di_Stens, di_Sones,
                       di_AMtens, di_AMones, di_AStens, di_ASones,
                       dicAlarmArmed, dicAlarmTrig);
        foreach (f[i]) mq.push_back(f[i]);
    endtask

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_step();
        bit s_ok;
        s_ok = oneSecStrb && fmt_en;
        if (mq.size() == 0) begin
            if (s_ok) push_live_frame();
        end else if (tx_ack && mq.size() == 1) begin
            void'(mq.pop_front());
            if (m_pending) begin
                push_live_frame();
                m_pending = s_ok;
            end else if (s_ok) begin
                push_live_frame();
            end
        end else begin
            if (tx_ack) void'(mq.pop_front());
            if (s_ok) begin
                if (m_pending) m_overrun = 1'b1;
                else m_pending = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        #1;
    endtask

    task automatic model_clear();
        mq.delete();
        m_pending = 1'b0;
        m_overrun = 1'b0;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        oneSecStrb = 1'b0;
        tx_ack     = 1'b0;
        fmt_en     = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic set_digits(input logic [3:0] mt, mo, st, so, amt, amo, ast, aso,
                              input logic armed, trig);
        di_Mtens = mt;   di_Mones = mo;   di_Stens = st;   di_Sones = so;
        di_AMtens = amt; di_AMones = amo; di_AStens = ast; di_ASones = aso;
        dicAlarmArmed = armed; dicAlarmTrig = trig;
    endtask

    task automatic test_reset();
        rst = 1'b0; oneSecStrb = 1'b0; fmt_en = 1'b1; tx_ack = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        #12;
        n_tests++; if (L3_tx_data_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b want 0", L3_tx_data_rdy); end
        n_tests++; if (L3_tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", L3_tx_data); end
        n_tests++; if (fmt_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", fmt_busy); end
        n_tests++; if (fmt_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", fmt_overrun); end
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        tx_ack = 1'b1;
        repeat (3) tick();
        n_tests++; if (L3_tx_data_rdy !== 1'b0) begin n_fail++; $display("FAIL idle_ack_ignored: rdy got %b want 0", L3_tx_data_rdy); end
    endtask

    task automatic test_basic_frame();
        logic [7:0] e [15];
        e = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h20, 8'h30, 8'h35, 8'h3A, 8'h33, 8'h30, 8'h20, 8'h41, 8'h0D, 8'h0A};
        do_reset();
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd5, 4'd3, 4'd0, 1'b1, 1'b0);
        tx_ack = 1'b1;
        oneSecStrb = 1'b1;
        tick();
        oneSecStrb = 1'b0;
        for (int i = 0; i < 15; i++) begin
            n_tests++;
            if ({L3_tx_data_rdy, fmt_busy, L3_tx_data} !== {1'b1, 1'b1, e[i]}) begin
                n_fail++; $display("FAIL basic_byte%0d: rdy=%b busy=%b data=%h want rdy=1 busy=1 data=%h", i, L3_tx_data_rdy, fmt_busy, L3_tx_data, e[i]);
            end
            tick();
        end
        n_tests++; if ({L3_tx_data_rdy, fmt_busy, L3_tx_data} !== 10'h000) begin n_fail++; $display("FAIL basic_idle: rdy=%b busy=%b data=%h want 0 0 00", L3_tx_data_rdy, fmt_busy, L3_tx_data); end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd5, 4'd3, 4'd0, 1'b1, 1'b0);
        tx_ack = 1'b1;
        oneSecStrb = 1'b1;
        tick();
        oneSecStrb = 1'b0;
        repeat (5) tick();
        tx_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({L3_tx_data_rdy, L3_tx_data} !== {1'b1, 8'h20}) begin
                n_fail++; $display("FAIL stall_cycle%0d: rdy=%b data=%h want rdy=1 data=20", i, L3_tx_data_rdy, L3_tx_data);
            end
        end
        tx_ack = 1'b1;
        tick();
        n_tests++; if (L3_tx_data !== 8'h30) begin n_fail++; $display("FAIL stall_resume: got %h want 30", L3_tx_data); end
        repeat (9) tick();
        n_tests++; if (L3_tx_data_rdy !== 1'b0) begin n_fail++; $display("FAIL stall_frame_len: rdy got %b want 0", L3_tx_data_rdy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e [15];
        frame_t f2;
        e = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h20, 8'h30, 8'h35, 8'h3A, 8'h33, 8'h30, 8'h20, 8'h41, 8'h0D, 8'h0A};
        do_reset();
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd5, 4'd3, 4'd0, 1'b1, 1'b0);
        tx_ack = 1'b1;
        oneSecStrb = 1'b1;
        tick();
        for (int k = 0; k < 15; k++) begin
            n_tests++;
            if ({L3_tx_data_rdy, L3_tx_data} !== {1'b1, e[k]}) begin
                n_fail++; $display("FAIL b2b_first%0d: rdy=%b data=%h want rdy=1 data=%h", k, L3_tx_data_rdy, L3_tx_data, e[k]);
            end
            oneSecStrb = (k == 7);
            if (k == 8) set_digits(4'd9, 4'd8, 4'd7, 4'd6, 4'd1, 4'd2, 4'd5, 4'd9, 1'b0, 1'b0);
            tick();
        end
        f2 = make_frame(4'd9, 4'd8, 4'd7, 4'd6, 4'd1, 4'd2, 4'd5, 4'd9, 1'b0, 1'b0);
        for (int j = 0; j < 15; j++) begin
            n_tests++;
            if ({L3_tx_data_rdy, fmt_busy, L3_tx_data} !== {1'b1, 1'b1, f2[j]}) begin
                n_fail++; $display("FAIL b2b_second%0d: rdy=%b busy=%b data=%h want 1 1 %h", j, L3_tx_data_rdy, fmt_busy, L3_tx_data, f2[j]);
            end
            tick();
        end
        n_tests++; if (fmt_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end: busy got %b want 0", fmt_busy); end
    endtask

    task automatic test_overrun();
        int bytes;
        do_reset();
        set_digits(4'd2, 4'd3, 4'd5, 4'd9, 4'd0, 4'd7, 4'd0, 4'd0, 1'b0, 1'b0);
        tx_ack = 1'b1;
        oneSecStrb = 1'b1;
        tick();
        bytes = 0;
        for (int c = 0; c < 200 && L3_tx_data_rdy; c++) begin
            bytes++;
            oneSecStrb = (c == 3 || c == 6);
            tick();
        end
        oneSecStrb = 1'b0;
        n_tests++; if (bytes !== 30) begin n_fail++; $display("FAIL overrun_frames: bytes got %0d want 30", bytes); end
        n_tests++; if (fmt_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_flag: got %b want 1", fmt_overrun); end
        repeat (6) tick();
        n_tests++; if (fmt_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b want 1", fmt_overrun); end
        #2;
        rst = 1'b0;
        #1;
        n_tests++; if (fmt_overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b want 0", fmt_overrun); end
        model_clear();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fmt_en();
        int bytes;
        do_reset();
        set_digits(4'd0, 4'd1, 4'd0, 4'd2, 4'd0, 4'd3, 4'd0, 4'd4, 1'b1, 1'b0);
        tx_ack = 1'b1;
        fmt_en = 1'b0;
        oneSecStrb = 1'b1;
        tick();
        n_tests++; if (L3_tx_data_rdy !== 1'b0) begin n_fail++; $display("FAIL en_blocks_idle: rdy got %b want 0", L3_tx_data_rdy); end
        fmt_en = 1'b1;
        tick();
        bytes = 0;
        for (int c = 0; c < 200 && L3_tx_data_rdy; c++) begin
            bytes++;
            oneSecStrb = (c == 2);
            fmt_en = (c <= 2);
            tick();
        end
        oneSecStrb = 1'b0;
        fmt_en = 1'b1;
        n_tests++; if (bytes !== 30) begin n_fail++; $display("FAIL en_pending_completes: bytes got %0d want 30", bytes); end
        n_tests++; if (fmt_overrun !== 1'b0) begin n_fail++; $display("FAIL en_no_overrun: got %b want 0", fmt_overrun); end
    endtask

    task automatic test_encoding();
        logic [7:0] got [15];
        frame_t f;
        do_reset();
        set_digits(4'd2, 4'd3, 4'd5, 4'hA, 4'd1, 4'd1, 4'd0, 4'hF, 1'b1, 1'b1);
        f = make_frame(4'd2, 4'd3, 4'd5, 4'hA, 4'd1, 4'd1, 4'd0, 4'hF, 1'b1, 1'b1);
        tx_ack = 1'b1;
        oneSecStrb = 1'b1;
        tick();
        oneSecStrb = 1'b0;
        for (int i = 0; i < 15; i++) begin
            got[i] = L3_tx_data;
            tick();
        end
        n_tests++; if (got[4] !== 8'h3F) begin n_fail++; $display("FAIL enc_bad_digit: got %h want 3F", got[4]); end
        n_tests++; if (got[12] !== 8'h21) begin n_fail++; $display("FAIL enc_trig_status: got %h want 21", got[12]); end
        n_tests++; if (got[10] !== 8'h3F) begin n_fail++; $display("FAIL enc_digit_f: got %h want 3F", got[10]); end
        for (int i = 0; i < 15; i++) begin
            n_tests++;
            if (got[i] !== f[i]) begin n_fail++; $display("FAIL enc_byte%0d: got %h want %h", i, got[i], f[i]); end
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd5, 4'd3, 4'd0, 1'b1, 1'b0);
        tx_ack = 1'b1;
        oneSecStrb = 1'b1;
        tick();
        oneSecStrb = 1'b0;
        repeat (9) tick();
        n_tests++; if (L3_tx_data !== 8'h33) begin n_fail++; $display("FAIL mid_idx9: got %h want 33", L3_tx_data); end
        #2;
        rst = 1'b0;
        #1;
        n_tests++; if ({L3_tx_data_rdy, fmt_busy, L3_tx_data} !== 10'h000) begin n_fail++; $display("FAIL mid_async_clear: rdy=%b busy=%b data=%h want 0 0 00", L3_tx_data_rdy, fmt_busy, L3_tx_data); end
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++; if (L3_tx_data_rdy !== 1'b0) begin n_fail++; $display("FAIL mid_no_resume%0d: rdy got %b want 0", i, L3_tx_data_rdy); end
        end
        oneSecStrb = 1'b1;
        tick();
        oneSecStrb = 1'b0;
        n_tests++; if ({L3_tx_data_rdy, L3_tx_data} !== {1'b1, 8'h31}) begin n_fail++; $display("FAIL mid_restart: rdy=%b data=%h want 1 31", L3_tx_data_rdy, L3_tx_data); end
        repeat (15) tick();
        n_tests++; if (L3_tx_data_rdy !== 1'b0) begin n_fail++; $display("FAIL mid_restart_len: rdy got %b want 0", L3_tx_data_rdy); end
    endtask

    task automatic test_release_strobe();
        rst = 1'b0;
        model_clear();
        set_digits(4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        oneSecStrb = 1'b1;
        tx_ack = 1'b0;
        tick();
        oneSecStrb = 1'b0;
        n_tests++; if ({L3_tx_data_rdy, L3_tx_data} !== {1'b1, 8'h37}) begin n_fail++; $display("FAIL release_first_edge: rdy=%b data=%h want 1 37", L3_tx_data_rdy, L3_tx_data); end
    endtask

    task automatic test_random();
        logic       exp_rdy;
        logic [7:0] exp_data;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
            tx_ack     = ($urandom_range(0, 3) != 0);
            fmt_en     = ($urandom_range(0, 4) != 0);
            oneSecStrb = ($urandom_range(0, 14) == 0);
            // Leave the request-during-queued-handover corner to the directed tests
            if (mq.size() == 1 && m_pending && tx_ack) oneSecStrb = 1'b0;
            tick();
            exp_rdy  = (mq.size() > 0);
            exp_data = exp_rdy ? mq[0] : 8'h00;
            n_tests++;
            if ({L3_tx_data_rdy, fmt_busy, L3_tx_data, fmt_overrun} !== {exp_rdy, exp_rdy, exp_data, m_overrun}) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL random_cycle%0d: rdy=%b busy=%b data=%h ovr=%b want rdy=%b busy=%b data=%h ovr=%b",
                    c, L3_tx_data_rdy, fmt_busy, L3_tx_data, fmt_overrun, exp_rdy, exp_rdy, exp_data, m_overrun);
            end
        end
        oneSecStrb = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_back_to_back();
        test_overrun();
        test_fmt_en();
        test_encoding();
        test_reset_midframe();
        test_release_strobe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
